// File: rtl/alu_result_select.sv
// Mode-selected ALU result/carry register with valid/ready handshake and a skid entry.
// Also produces zero/illegal-mode flags and a saturating illegal-mode counter.

module alu_result_select_lane #(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 1,
  parameter int IDX    = 0
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  result,
  input  logic              cout,
  output logic              hit,
  output logic [WIDTH-1:0]  result_m,
  output logic              cout_m
);
  localparam logic [MODE_W-1:0] IDX_C = MODE_W'(IDX);

  assign hit      = (mode == IDX_C);
  assign result_m = hit ? result : '0;
  assign cout_m   = hit & cout;
endmodule

module alu_result_select #(
  parameter int WIDTH     = 8,
  parameter int NUM_UNITS = 2,
  parameter int MODE_W    = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MODE_W-1:0]          mode,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS-1:0]       unit_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result_final,
  output logic                       cout_final,
  output logic                       zero_flag,
  output logic                       mode_err,
  output logic [ERR_CNT_W-1:0]       err_count
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             err;
  } beat_t;

  logic [NUM_UNITS-1:0][WIDTH-1:0] res_u;
  logic [NUM_UNITS-1:0][WIDTH-1:0] res_m;
  logic [NUM_UNITS-1:0]            cout_m;
  logic [NUM_UNITS-1:0]            hit;

  assign res_u = unit_result;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_lane
    alu_result_select_lane #(.WIDTH(WIDTH), .MODE_W(MODE_W), .IDX(k)) u_lane (
      .mode     (mode),
      .result   (res_u[k]),
      .cout     (unit_cout[k]),
      .hit      (hit[k]),
      .result_m (res_m[k]),
      .cout_m   (cout_m[k])
    );
  end

  // Lanes are one-hot masked, so OR-reduction is the mux; no hit means illegal mode.
  beat_t sel;
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      sel.result = sel.result | res_m[k];
      sel.cout   = sel.cout | cout_m[k];
    end
    sel.err  = ~|hit;
    sel.zero = (sel.result == '0);
  end

  beat_t out_q, skid_q;
  logic  skid_valid;
  logic  accept, consume;

  assign in_ready = !skid_valid && !reset;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      err_count  <= '0;
    end else begin
      if (skid_valid) begin
        if (consume) begin
          out_q      <= skid_q;
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!out_valid || consume) begin
          out_q     <= sel;
          out_valid <= 1'b1;
        end else begin
          skid_q     <= sel;
          skid_valid <= 1'b1;
        end
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (accept && sel.err && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

  assign result_final = out_q.result;
  assign cout_final   = out_q.cout;
  assign zero_flag    = out_q.zero;
  assign mode_err     = out_q.err;
endmodule
